// File: rtl/cspi_pkg.sv
// Shared definitions for the SPI command sequencer: FSM encoding,
// default MISO marker bytes and the command-byte field layout.
package cspi_pkg;

  // 3-bit state codes
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_WR      = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;
  localparam logic [2:0] ST_RD_HOLD = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_CMD     = ST_CMD,
    S_WR      = ST_WR,
    S_RD_REQ  = ST_RD_REQ,
    S_RD_WAIT = ST_RD_WAIT,
    S_RD_HOLD = ST_RD_HOLD
  } cspi_state_e;

  // MISO marker bytes
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] ERR_BYTE_DEF  = 8'hEE;
  localparam logic [7:0] CTRL_Q_RST    = 8'hFF;

  // Command byte: bit 7 selects read (1) or write (0), bits 6:0 the address
  localparam int unsigned RW_BIT = 7;

  // Burst address step; 7'h7F rolls over to 7'h00
  function automatic logic [6:0] addr_inc(input logic [6:0] a);
    return a + 7'd1;
  endfunction

endpackage

// File: rtl/cspi_cmd.sv
// SPI command sequencer: turns the received MOSI byte stream into register
// bus reads/writes with auto-increment bursts, and hands read data back
// as the next MISO byte. Reads are prefetched one byte ahead of the master.
module cspi_cmd
  import cspi_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter logic [7:0] ERR_BYTE  = ERR_BYTE_DEF,
  parameter logic [7:0] RD_TO     = 8'd255
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       csn,
  input  logic [7:0] ctrl_data,
  input  logic       ctrl_dvld,
  output logic [7:0] ctrl_q,
  output logic       ctrl_qvld,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  input  logic       reg_rvld,
  output logic       rd_err,
  output logic       ovr_err
);

  cspi_state_e state_q;
  logic [6:0]  addr_q;
  logic [7:0]  to_cnt_q;
  logic [7:0]  ctrl_q_q;
  logic        ctrl_qvld_q;
  logic [6:0]  reg_addr_q;
  logic [7:0]  reg_wdata_q;
  logic        reg_wr_q;
  logic        reg_rd_q;
  logic        rd_err_q;
  logic        ovr_err_q;

  // Frame sequencer; every output is registered and strobes default low
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      to_cnt_q    <= '0;
      ctrl_q_q    <= CTRL_Q_RST;
      ctrl_qvld_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      rd_err_q    <= 1'b0;
      ovr_err_q   <= 1'b0;
    end else begin
      ctrl_qvld_q <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      rd_err_q    <= 1'b0;
      ovr_err_q   <= 1'b0;
      if (csn && (state_q != S_IDLE)) begin
        // Chip select released: drop the frame, abandon any pending read
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!csn) begin
              ctrl_q_q    <= SYNC_BYTE;
              ctrl_qvld_q <= 1'b1;
              state_q     <= S_CMD;
            end
          end
          S_CMD: begin
            if (ctrl_dvld) begin
              addr_q  <= ctrl_data[6:0];
              state_q <= ctrl_data[RW_BIT] ? S_RD_REQ : S_WR;
            end
          end
          S_WR: begin
            if (ctrl_dvld) begin
              reg_wdata_q <= ctrl_data;
              reg_addr_q  <= addr_q;
              reg_wr_q    <= 1'b1;
              addr_q      <= addr_inc(addr_q);
            end
          end
          S_RD_REQ: begin
            reg_rd_q   <= 1'b1;
            reg_addr_q <= addr_q;
            to_cnt_q   <= '0;
            state_q    <= S_RD_WAIT;
            if (ctrl_dvld) ovr_err_q <= 1'b1;
          end
          S_RD_WAIT: begin
            if (reg_rvld) begin
              ctrl_q_q    <= reg_rdata;
              ctrl_qvld_q <= 1'b1;
              addr_q      <= addr_inc(addr_q);
              state_q     <= S_RD_HOLD;
            end else if (to_cnt_q == RD_TO) begin
              ctrl_q_q    <= ERR_BYTE;
              ctrl_qvld_q <= 1'b1;
              rd_err_q    <= 1'b1;
              addr_q      <= addr_inc(addr_q);
              state_q     <= S_RD_HOLD;
            end else begin
              to_cnt_q <= to_cnt_q + 8'd1;
              if (ctrl_dvld) ovr_err_q <= 1'b1;
            end
          end
          S_RD_HOLD: begin
            // Master has shifted out the prefetched byte: fetch the next one
            if (ctrl_dvld) state_q <= S_RD_REQ;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ctrl_q    = ctrl_q_q;
  assign ctrl_qvld = ctrl_qvld_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign rd_err    = rd_err_q;
  assign ovr_err   = ovr_err_q;

endmodule
